// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the fetch PC, issues word requests to instruction memory and buffers
// {pc, instr} pairs for decode. Define FETCH_PERF_CNT_EN to add fetch/stall counters.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_FULL = 1'b1;

    logic [0:0]       state, state_next;
    logic [31:0]      fetch_pc;
    logic [CNT_W-1:0] count, count_next;
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [31:0]      pc_buf   [DEPTH];
    logic [31:0]      data_buf [DEPTH];
    logic             push, pop;
    logic             unused_redirect_lsbs;

    // Redirect masks both sides of the buffer so a flush never races a push or pop.
    assign imem_req    = (state == ST_RUN) && !redirect_valid && !reset;
    assign imem_addr   = fetch_pc;
    assign push        = imem_req && imem_ready;
    assign instr_valid = (count != '0);
    assign pop         = instr_valid && instr_ready && !redirect_valid;
    assign instr       = data_buf[rd_ptr];
    assign instr_pc    = pc_buf[rd_ptr];

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        count_next = count;
        if (redirect_valid) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !push) begin
            count_next = count - 1'b1;
        end
        state_next = (count_next == FULL_CNT) ? ST_FULL : ST_RUN;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_RUN;
            fetch_pc <= RESET_PC;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (redirect_valid) begin
                fetch_pc <= {redirect_pc[31:2], 2'b00};
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (push) begin
                    fetch_pc <= fetch_pc + 32'd4;
                    wr_ptr   <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
        end
    end

    // NOTE: the buffer is cleared on reset so instr/instr_pc read a defined entry 0 after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_buf[i]   <= '0;
                data_buf[i] <= '0;
            end
        end else if (push) begin
            pc_buf[wr_ptr]   <= fetch_pc;
            data_buf[wr_ptr] <= imem_rdata;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // A stall is a full buffer or a request the memory has not yet accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            if (push) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if ((state == ST_FULL) || (imem_req && !imem_ready)) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a queue scoreboard records each completed fetch and
// checks it when it reaches the buffer head.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    int          errors = 0;
    int          checks = 0;
    entry_t      model_q[$];
    logic [31:0] model_pc = RESET_PC;
    logic [31:0] model_fetch = 0;
    logic [31:0] model_stall = 0;

    instr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_ready   (instr_ready)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count   (fetch_count),
        .stall_count   (stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step(input bit mem_rdy, input bit dec_rdy, input bit redir,
                        input logic [31:0] rpc);
        logic [31:0] rd;
        bit          exp_req, push, pop, have;
        entry_t      e;
        rd             = $urandom;
        imem_ready     = mem_rdy;
        instr_ready    = dec_rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_rdata     = rd;
        #1;
        have    = (model_q.size() != 0);
        exp_req = (model_q.size() < DEPTH) && !redir;
        check("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
        check("imem_addr", imem_addr, model_pc);
        check("instr_valid", {31'b0, instr_valid}, {31'b0, have});
        if (have) begin
            e = model_q[0];
            check("instr_pc", instr_pc, e.pc);
            check("instr", instr, e.data);
        end
`ifdef FETCH_PERF_CNT_EN
        check("fetch_count", fetch_count, model_fetch);
        check("stall_count", stall_count, model_stall);
`endif
        push = exp_req && mem_rdy;
        pop  = have && dec_rdy && !redir;
        if ((model_q.size() == DEPTH) || (exp_req && !mem_rdy)) model_stall++;
        if (push) model_fetch++;
        if (redir) begin
            model_q.delete();
            model_pc = {rpc[31:2], 2'b00};
        end else begin
            if (pop) void'(model_q.pop_front());
            if (push) begin
                e.pc   = model_pc;
                e.data = rd;
                model_q.push_back(e);
                model_pc = model_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset          = 1'b1;
        imem_ready     = 1'b1;
        imem_rdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b1;
        @(posedge clk);
        #1;
        check("rst_imem_req", {31'b0, imem_req}, 32'd0);
        check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_imem_addr", imem_addr, RESET_PC);
        check("rst_instr", instr, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        reset = 1'b0;

        // Streaming: one fetch per cycle from RESET_PC.
        for (int i = 0; i < 6; i++) step(1, 1, 0, '0);

        // Decode stalled: buffer fills at 0x0/0x4, request drops with 0x8 held.
        step(0, 1, 1, 32'h0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, '0);
        for (int i = 0; i < 4; i++) step(1, 1, 0, '0);

        // Memory stall at 0x10 for three cycles.
        step(1, 1, 1, 32'h10);
        for (int i = 0; i < 3; i++) step(0, 1, 0, '0);
        for (int i = 0; i < 3; i++) step(1, 1, 0, '0);

        // Redirect with a full buffer; misaligned target 0x103 lands at 0x100.
        step(1, 1, 1, 32'h20);
        step(1, 0, 0, '0);
        step(1, 0, 0, '0);
        step(1, 1, 1, 32'h103);
        check("flush_instr_valid", {31'b0, instr_valid}, 32'd0);
        check("flush_addr", imem_addr, 32'h100);
        for (int i = 0; i < 4; i++) step(1, 1, 0, '0);

        // PC wrap and back-to-back redirects.
        step(1, 1, 1, 32'hFFFF_FFF8);
        for (int i = 0; i < 4; i++) step(1, 1, 0, '0);
        step(1, 1, 1, 32'h200);
        step(1, 1, 1, 32'h302);
        for (int i = 0; i < 3; i++) step(1, 1, 0, '0);

        // Asynchronous reset mid-stall with the buffer full.
        step(1, 0, 1, 32'h40);
        for (int i = 0; i < 3; i++) step(1, 0, 0, '0);
        reset = 1'b1;
        #1;
        check("async_rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        check("async_rst_imem_req", {31'b0, imem_req}, 32'd0);
        check("async_rst_addr", imem_addr, RESET_PC);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_q.delete();
        model_pc    = RESET_PC;
        model_fetch = 0;
        model_stall = 0;

        // Ten completions plus three memory-stall cycles.
        for (int i = 0; i < 10; i++) step(1, 1, 0, '0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, '0);
`ifdef FETCH_PERF_CNT_EN
        check("perf_fetch_count", fetch_count, 32'd10);
        check("perf_stall_count", stall_count, 32'd3);
`endif
        for (int i = 0; i < 3; i++) step(1, 1, 0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
